// File: rtl/operand_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_deserializer_pkg
// Description : Shared types and constants for the serial operand
//               deserializer: FSM state encoding, frame/timeout sizes,
//               operation-select encoding and a saturating counter helper.
//               Timeout behaviour is compiled in with DESER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_deserializer_pkg;

  localparam int FRAME_BITS      = 32;
  localparam int TIMEOUT_SAMPLES = 40;
  localparam int CNT_W           = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_ACK  = 2'd2
  } deser_state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_sel_e;

  // Sample counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_deserializer_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : serial_shift_reg
// Description : Serial-in shift register, new bit enters at the LSB and the
//               oldest bit leaves at the MSB. Synchronous clear discards the
//               accumulated history.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_shift_reg
  import operand_deserializer_pkg::*;
#(
  parameter int WIDTH = FRAME_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             clr_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;

  // Shift the serial bit in on enable; reset and clear both empty the register.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      data_q <= '0;
    end else if (shift_en_i) begin
      data_q <= {data_q[WIDTH-2:0], bit_i};
    end
  end

  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/operand_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : operand_deserializer
// Description : Receives two MSB-first serial operands plus an operation
//               select from an upstream source, assembles them into 32-bit
//               words and presents them to the FPU over a valid/ready
//               handshake. The frame's final bit is taken live on the ok
//               cycle, so the word is the 31 buffered samples plus that bit.
//               Optional receive timeout: define DESER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_deserializer
  import operand_deserializer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        num1_bit,
  input  logic        num2_bit,
  input  logic        select0,
  input  logic        select1,
  input  logic        ok,
  output logic        dataready,
  output logic        stop,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [1:0]  op_sel,
  output logic [1:0]  frame_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_err
);

  deser_state_e           state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dataready_q, dataready_d;
  logic                   stop_q, stop_d;
  logic                   out_valid_q, out_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic [FRAME_BITS-1:0]  opa_q, opa_d;
  logic [FRAME_BITS-1:0]  opb_q, opb_d;
  logic [1:0]             op_sel_q, op_sel_d;
  logic [1:0]             frame_idx_q, frame_idx_d;

  logic                   w_shift_en;
  logic                   w_shift_clr;
  logic                   w_slot_free;
  logic                   w_timeout;
  logic [FRAME_BITS-1:0]  w_a_hist;
  logic [FRAME_BITS-1:0]  w_b_hist;
  logic                   w_unused_msb;

  serial_shift_reg #(.WIDTH(FRAME_BITS)) u_shift_a (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (w_shift_en),
    .clr_i      (w_shift_clr),
    .bit_i      (num1_bit),
    .data_o     (w_a_hist)
  );

  serial_shift_reg #(.WIDTH(FRAME_BITS)) u_shift_b (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (w_shift_en),
    .clr_i      (w_shift_clr),
    .bit_i      (num2_bit),
    .data_o     (w_b_hist)
  );

  // The oldest buffered bit is always displaced by the live bit at capture.
  assign w_unused_msb = w_a_hist[FRAME_BITS-1] ^ w_b_hist[FRAME_BITS-1];

  // Output slot can accept a new word if empty or being drained this cycle.
  assign w_slot_free = !out_valid_q || out_ready;

`ifdef DESER_TIMEOUT_EN
  assign w_timeout = (state_q == ST_RECV) && !ok &&
                     (cnt_q == CNT_W'(TIMEOUT_SAMPLES));
`else
  assign w_timeout = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dataready_q <= 1'b0;
      stop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      op_sel_q    <= 2'b00;
      frame_idx_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dataready_q <= dataready_d;
      stop_q      <= stop_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      op_sel_q    <= op_sel_d;
      frame_idx_q <= frame_idx_d;
    end
  end

  // Next-state, shift control and output-register next values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dataready_d = dataready_q;
    stop_d      = 1'b0;
    frame_err_d = 1'b0;
    out_valid_d = out_valid_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    op_sel_d    = op_sel_q;
    frame_idx_d = frame_idx_q;
    w_shift_en  = 1'b0;
    w_shift_clr = 1'b0;

    // A consumed word empties the slot unless a capture refills it below.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        dataready_d = 1'b0;
        if (ok) begin
          // Upstream still thinks a frame is open: acknowledge to flush it.
          stop_d = 1'b1;
        end else if (enable) begin
          dataready_d = 1'b1;
          state_d     = ST_RECV;
        end
      end

      ST_RECV: begin
        dataready_d = 1'b1;
        if (w_timeout) begin
          frame_err_d = 1'b1;
          dataready_d = 1'b0;
          cnt_d       = '0;
          w_shift_clr = 1'b1;
          state_d     = ST_IDLE;
        end else if (!ok) begin
          w_shift_en = 1'b1;
          cnt_d      = sat_inc(cnt_q);
        end else if (w_slot_free) begin
          opa_d       = {w_a_hist[FRAME_BITS-2:0], num1_bit};
          opb_d       = {w_b_hist[FRAME_BITS-2:0], num2_bit};
          op_sel_d    = {select1, select0};
          out_valid_d = 1'b1;
          frame_idx_d = frame_idx_q + 2'd1;
          dataready_d = 1'b0;
          stop_d      = 1'b1;
          state_d     = ST_ACK;
        end
        // ok with a full slot: hold everything until the FPU drains it.
      end

      ST_ACK: begin
        dataready_d = 1'b0;
        cnt_d       = '0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dataready = dataready_q;
  assign stop      = stop_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign operand_a = opa_q;
  assign operand_b = opb_q;
  assign op_sel    = op_sel_q;
  assign frame_idx = frame_idx_q;

endmodule
`default_nettype wire
